// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Frame controller for the UART transmitter. It accepts a byte over a
// valid/ready handshake and sequences the serializer. It muxes the
// start/data/parity/stop bits onto the line. One clk cycle is one bit period.
//
// Parameters
//   DATA_WIDTH  data bits per frame, LSB first
//   STOP_BITS   stop-bit count, 1 or 2
//
// Ports
//   clk         baud-rate clock, rising edge
//   rst_n       asynchronous active-low reset
//   data_valid  upstream byte available on P_DATA
//   P_DATA      byte to send, sampled on accept
//   par_en      frame carries a parity bit (sampled on accept)
//   par_typ     0 = even, 1 = odd parity (sampled on accept)
//   tx_ready    controller can accept a byte this cycle
//   ser_pdata   latched byte, parallel load value for the serializer
//   ser_en      serializer shift enable
//   ser_data    serializer output bit
//   ser_done    serializer flags its last data bit on ser_data
//   TX_OUT      UART line, idle high
//   busy        frame in progress
//   sync_err    one-cycle pulse when ser_done disagrees with the bit count
//
// All outputs are decodes of registered state. TX_OUT additionally passes
// ser_data through during DATA, and sync_err compares the live ser_done
// input.
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  data_valid,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] ser_pdata,
   output logic                  ser_en,
   input  logic                  ser_data,
   input  logic                  ser_done,
   output logic                  TX_OUT,
   output logic                  busy,
   output logic                  sync_err
);

   localparam int unsigned CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int unsigned STOP_W = 1;

   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
   localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   state_e                state_q,    state_d;
   logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
   logic [STOP_W-1:0]     stop_cnt_q, stop_cnt_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q;
   logic                  parity_q;

   logic                  last_stop_c;
   logic                  last_bit_c;
   logic                  accept_c;

   // Handshake decode; the last stop cycle is also an accept slot for back-to-back frames
   assign last_stop_c = (state_q == STOP) && (stop_cnt_q == LAST_STOP);
   assign last_bit_c  = (bit_cnt_q == LAST_BIT);
   assign tx_ready    = (state_q == IDLE) || last_stop_c;
   assign accept_c    = data_valid && tx_ready;
   assign busy        = (state_q != IDLE);
   assign ser_pdata   = data_q;

   // State and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         stop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
      end
   end

   // Byte and frame options captured on accept; parity is folded with its type up front
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         par_en_q <= 1'b0;
         parity_q <= 1'b0;
      end else if (accept_c) begin
         data_q   <= P_DATA;
         par_en_q <= par_en;
         parity_q <= (^P_DATA) ^ par_typ;
      end
   end

   // Next-state and line mux
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      TX_OUT     = 1'b1;
      ser_en     = 1'b0;
      sync_err   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept_c) state_d = START;
         end

         // The serializer loads during START, so bit 0 is on ser_data in the first DATA cycle
         START: begin
            TX_OUT    = 1'b0;
            ser_en    = 1'b1;
            bit_cnt_d = '0;
            state_d   = DATA;
         end

         // Frame length is owned by bit_cnt; ser_done is only cross-checked
         DATA: begin
            TX_OUT    = ser_data;
            ser_en    = !last_bit_c;
            sync_err  = ser_done ^ last_bit_c;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (last_bit_c) begin
               if (par_en_q) begin
                  state_d = PARITY;
               end else begin
                  state_d    = STOP;
                  stop_cnt_d = '0;
               end
            end
         end

         PARITY: begin
            TX_OUT     = parity_q;
            state_d    = STOP;
            stop_cnt_d = '0;
         end

         STOP: begin
            TX_OUT     = 1'b1;
            stop_cnt_d = stop_cnt_q + STOP_W'(1);
            if (last_stop_c) state_d = accept_c ? START : IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Bench with two controller lanes: lane 0 uses one stop bit and lane 1 uses
// two. Each lane has a small serializer model downstream. The expected line
// waveform per frame comes from hand-written vectors or from a queue-built
// reference frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [1:0]       dv, pe, pt, inj;
   logic [1:0]       rdy, sen, tx, busy, serr;
   logic [1:0][W-1:0] pdata, spdata;

   int n_checks = 0;
   int n_fail   = 0;

   // One controller per lane, each feeding its own serializer model
   for (genvar g = 0; g < 2; g++) begin : g_lane
      logic         sd;
      logic         act;
      logic         mdone;
      logic [W-1:0] sh;
      logic [3:0]   idx;

      // Serializer: loads on the first enabled edge, shifts on each further one, disarms when ser_en drops
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            act <= 1'b0;
            idx <= '0;
            sh  <= '0;
            sd  <= 1'b0;
         end else if (sen[g]) begin
            if (!act) begin
               act <= 1'b1;
               idx <= '0;
               sd  <= spdata[g][0];
               sh  <= spdata[g] >> 1;
            end else begin
               idx <= idx + 4'd1;
               sd  <= sh[0];
               sh  <= sh >> 1;
            end
         end else begin
            act <= 1'b0;
         end
      end

      assign mdone = act && (idx == 4'(W - 1));

      uart_tx_ctrl #(.DATA_WIDTH(W), .STOP_BITS(g + 1)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .data_valid (dv[g]),
         .P_DATA     (pdata[g]),
         .par_en     (pe[g]),
         .par_typ    (pt[g]),
         .tx_ready   (rdy[g]),
         .ser_pdata  (spdata[g]),
         .ser_en     (sen[g]),
         .ser_data   (sd),
         .ser_done   (mdone | inj[g]),
         .TX_OUT     (tx[g]),
         .busy       (busy[g]),
         .sync_err   (serr[g])
      );
   end

   typedef struct {
      int           lane;
      logic [W-1:0] d;
      bit           e;
      bit           t;
      int           len;
      logic [11:0]  bits;   // line value of frame cycle k in bit k
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference frame: start bit, data LSB first, optional parity, stop bits
   function automatic void ref_frame(input logic [W-1:0] d, input bit e, input bit t,
                                     input int ns, output logic [11:0] b, output int len);
      bit q[$];
      q.push_back(1'b0);
      for (int n = 0; n < W; n++) q.push_back(d[n]);
      if (e) q.push_back(((($countones(d) + int'(t)) % 2) == 1));
      for (int n = 0; n < ns; n++) q.push_back(1'b1);
      b = '0;
      foreach (q[n]) b[n] = q[n];
      len = q.size();
   endfunction

   // Present a byte while idle; returns at the negedge of the START cycle
   task automatic start_frame(input int i, input logic [W-1:0] d, input bit e, input bit t);
      dv[i] = 1'b1; pdata[i] = d; pe[i] = e; pt[i] = t;
      #1;
      chk($sformatf("lane%0d ready_before_accept", i), 32'(rdy[i]), 32'd1);
      @(negedge clk);
   endtask

   task automatic chk_idle(input int i, input string tag);
      #1;
      chk($sformatf("lane%0d %s idle busy", i, tag), 32'(busy[i]), 32'd0);
      chk($sformatf("lane%0d %s idle TX_OUT", i, tag), 32'(tx[i]), 32'd1);
      chk($sformatf("lane%0d %s idle tx_ready", i, tag), 32'(rdy[i]), 32'd1);
   endtask

   // Check every cycle of one frame, starting at the negedge of START
   task automatic watch_frame(input int i, input logic [11:0] bits, input int len,
                              input int inj_at, input bit hold, input bit nxt,
                              input logic [W-1:0] nd, input bit npe, input bit npt,
                              input int noise_at);
      for (int k = 0; k < len; k++) begin
         inj[i] = (k == inj_at);
         if (k == len - 1 && nxt) begin
            dv[i] = 1'b1; pdata[i] = nd; pe[i] = npe; pt[i] = npt;
         end else if (k == noise_at) begin
            dv[i] = 1'b1; pdata[i] = 8'h3C;
         end else if (!hold) begin
            dv[i] = 1'b0;
         end
         #1;
         chk($sformatf("lane%0d k%0d TX_OUT", i, k), 32'(tx[i]), 32'(bits[k]));
         chk($sformatf("lane%0d k%0d busy", i, k), 32'(busy[i]), 32'd1);
         chk($sformatf("lane%0d k%0d ser_en", i, k), 32'(sen[i]), 32'(k < W));
         chk($sformatf("lane%0d k%0d tx_ready", i, k), 32'(rdy[i]), 32'(k == len - 1));
         chk($sformatf("lane%0d k%0d sync_err", i, k), 32'(serr[i]), 32'(k == inj_at));
         @(negedge clk);
      end
      inj[i] = 1'b0;
      if (!nxt) dv[i] = 1'b0;
   endtask

   initial begin
      logic [11:0]  rb;
      int           rl;
      logic [W-1:0] cur_d, nd;
      bit           cur_e, cur_t, ne, nt, chain;

      vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 10, 12'h34A};   // 8N1 A5
      vecs[1] = '{0, 8'hA5, 1'b1, 1'b0, 11, 12'h54A};   // 8E1 A5, parity 0
      vecs[2] = '{0, 8'h01, 1'b1, 1'b1, 11, 12'h402};   // 8O1 01, parity 0
      vecs[3] = '{0, 8'h01, 1'b1, 1'b0, 11, 12'h602};   // 8E1 01, parity 1
      vecs[4] = '{0, 8'h00, 1'b0, 1'b0, 10, 12'h200};   // 8N1 00
      vecs[5] = '{0, 8'hFF, 1'b1, 1'b1, 11, 12'h7FE};   // 8O1 FF, parity 1
      vecs[6] = '{0, 8'hFF, 1'b0, 1'b1, 10, 12'h3FE};   // 8N1 FF, par_typ ignored
      vecs[7] = '{1, 8'hA5, 1'b0, 1'b0, 11, 12'h74A};   // 8N2 A5
      vecs[8] = '{1, 8'hA5, 1'b1, 1'b1, 12, 12'hF4A};   // 8O2 A5, parity 1

      rst_n = 1'b0;
      dv = '0; pe = '0; pt = '0; inj = '0; pdata = '0;
      #2;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("lane%0d reset TX_OUT", i), 32'(tx[i]), 32'd1);
         chk($sformatf("lane%0d reset ser_en", i), 32'(sen[i]), 32'd0);
         chk($sformatf("lane%0d reset busy", i), 32'(busy[i]), 32'd0);
         chk($sformatf("lane%0d reset tx_ready", i), 32'(rdy[i]), 32'd1);
         chk($sformatf("lane%0d reset sync_err", i), 32'(serr[i]), 32'd0);
         chk($sformatf("lane%0d reset ser_pdata", i), 32'(spdata[i]), 32'd0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single frames from the vector table
      foreach (vecs[v]) begin
         start_frame(vecs[v].lane, vecs[v].d, vecs[v].e, vecs[v].t);
         watch_frame(vecs[v].lane, vecs[v].bits, vecs[v].len, -1, 1'b0, 1'b0, '0, 1'b0, 1'b0, -1);
         chk_idle(vecs[v].lane, $sformatf("vec%0d", v));
      end

      // Back-to-back with data_valid held high: 55 then FF, no idle cycle between
      start_frame(0, 8'h55, 1'b0, 1'b0);
      watch_frame(0, 12'h2AA, 10, -1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, -1);
      watch_frame(0, 12'h3FE, 10, -1, 1'b0, 1'b0, '0, 1'b0, 1'b0, -1);
      chk_idle(0, "b2b");

      // A byte offered mid-frame is dropped, not queued
      start_frame(0, 8'h55, 1'b0, 1'b0);
      watch_frame(0, 12'h2AA, 10, -1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 4);
      chk_idle(0, "ignored0");
      chk("ignored ser_pdata", 32'(spdata[0]), 32'h55);
      @(negedge clk);
      chk_idle(0, "ignored1");

      // Reset in the middle of DATA, then a clean frame
      start_frame(0, 8'hC3, 1'b0, 1'b0);
      dv[0] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("pre-reset busy", 32'(busy[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midreset TX_OUT", 32'(tx[0]), 32'd1);
      chk("midreset ser_en", 32'(sen[0]), 32'd0);
      chk("midreset busy", 32'(busy[0]), 32'd0);
      chk("midreset tx_ready", 32'(rdy[0]), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_frame(0, 8'h81, 1'b0, 1'b0);
      watch_frame(0, 12'h302, 10, -1, 1'b0, 1'b0, '0, 1'b0, 1'b0, -1);
      chk_idle(0, "post-reset");

      // 8N2 with ser_done raised early at data bit 5
      start_frame(1, 8'h5A, 1'b0, 1'b0);
      watch_frame(1, 12'h6B4, 11, 6, 1'b0, 1'b0, '0, 1'b0, 1'b0, -1);
      chk_idle(1, "early_done");

      // Random frames, randomly chained back-to-back, on both lanes
      for (int i = 0; i < 2; i++) begin
         cur_d = W'($urandom);
         cur_e = 1'($urandom);
         cur_t = 1'($urandom);
         start_frame(i, cur_d, cur_e, cur_t);
         for (int j = 0; j < 12; j++) begin
            nd    = W'($urandom);
            ne    = 1'($urandom);
            nt    = 1'($urandom);
            chain = (j < 11) && ($urandom_range(0, 1) == 1);
            ref_frame(cur_d, cur_e, cur_t, i + 1, rb, rl);
            watch_frame(i, rb, rl, -1, 1'b0, chain, nd, ne, nt, -1);
            if (!chain) begin
               chk_idle(i, $sformatf("rand%0d", j));
               if (j < 11) start_frame(i, nd, ne, nt);
            end
            cur_d = nd; cur_e = ne; cur_t = nt;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
